// File: rtl/bloco_operacional.sv
// rtl/bloco_operacional.sv - datapath with X/H/S registers and a result register R fed by an add or an iterative multiply
// A change of {m0,m1,m2,h}, or a write to X/H on the previous edge, starts a new operation on R.

module bloco_operacional #(
    parameter logic [7:0] K0 = 8'd3,
    parameter logic [7:0] K1 = 8'd5,
    parameter logic [7:0] K2 = 8'd7
) (
    input  logic        ck,
    input  logic        rst,
    input  logic [7:0]  x_in,
    input  logic        lx,
    input  logic [1:0]  m0,
    input  logic [1:0]  m1,
    input  logic [1:0]  m2,
    input  logic        h,
    input  logic        lh,
    input  logic        ls,
    output logic [15:0] s_out,
    output logic        pronto,
    output logic        err
);

    logic [7:0]  x_q, x_d;
    logic [15:0] h_q, h_d;
    logic [15:0] s_q, s_d;
    logic [15:0] r_q, r_d;
    logic [6:0]  key_q, key_d;
    logic        load_q, load_d;
    logic [2:0]  cnt_q, cnt_d;
    logic        pronto_q, pronto_d;
    logic        err_q, err_d;
    logic [15:0] a_q, a_d;
    logic [7:0]  b_q, b_d;
    logic [15:0] add_q, add_d;
    logic        op_q, op_d;
    logic [15:0] acc_q, acc_d;

    logic [6:0]  key_now;
    logic        start;
    logic [15:0] op_a;
    logic [7:0]  op_b;
    logic [15:0] addend;
    logic [15:0] acc_sum;

    always_comb begin
        key_now = {m0, m1, m2, h};
        start   = (key_now != key_q) || load_q;

        case (m0)
            2'b00:   op_a = 16'd0;
            2'b01:   op_a = {8'd0, x_q};
            default: op_a = h_q;
        endcase
        case (m1)
            2'b00:   op_b = x_q;
            2'b01:   op_b = K1;
            2'b10:   op_b = K2;
            default: op_b = h_q[7:0];
        endcase
        case (m2)
            2'b00:   addend = 16'd0;
            2'b01:   addend = {8'd0, x_q};
            2'b10:   addend = {8'd0, K2};
            default: addend = {8'd0, K0};
        endcase

        x_d      = x_q;
        h_d      = h_q;
        s_d      = s_q;
        r_d      = r_q;
        key_d    = key_q;
        cnt_d    = cnt_q;
        pronto_d = pronto_q;
        err_d    = err_q;
        a_d      = a_q;
        b_d      = b_q;
        add_d    = add_q;
        op_d     = op_q;
        acc_d    = acc_q;
        acc_sum  = acc_q + (b_q[0] ? a_q : 16'd0);

        // A new start always wins over whatever operation is still running.
        if (start) begin
            a_d      = op_a;
            b_d      = op_b;
            add_d    = addend;
            op_d     = h;
            key_d    = key_now;
            pronto_d = 1'b0;
            cnt_d    = 3'd0;
            acc_d    = 16'd0;
        end else if (!pronto_q) begin
            if (!op_q) begin
                r_d      = a_q + add_q;
                pronto_d = 1'b1;
            end else begin
                acc_d = acc_sum;
                a_d   = a_q << 1;
                b_d   = b_q >> 1;
                cnt_d = cnt_q + 3'd1;
                if (cnt_q == 3'd7) begin
                    r_d      = acc_sum;
                    pronto_d = 1'b1;
                end
            end
        end

        if (lx) begin
            x_d = x_in;
        end
        load_d = lx || (lh && pronto_q);
        if (lh) begin
            if (pronto_q) h_d = r_q;
            else          err_d = 1'b1;
        end
        if (ls) begin
            if (pronto_q) s_d = r_q;
            else          err_d = 1'b1;
        end
    end

    always_ff @(posedge ck) begin
        if (rst) begin
            x_q      <= 8'd0;
            h_q      <= 16'd0;
            s_q      <= 16'd0;
            r_q      <= 16'd0;
            key_q    <= 7'd0;
            load_q   <= 1'b0;
            cnt_q    <= 3'd0;
            pronto_q <= 1'b1;
            err_q    <= 1'b0;
            a_q      <= 16'd0;
            b_q      <= 8'd0;
            add_q    <= 16'd0;
            op_q     <= 1'b0;
            acc_q    <= 16'd0;
        end else begin
            x_q      <= x_d;
            h_q      <= h_d;
            s_q      <= s_d;
            r_q      <= r_d;
            key_q    <= key_d;
            load_q   <= load_d;
            cnt_q    <= cnt_d;
            pronto_q <= pronto_d;
            err_q    <= err_d;
            a_q      <= a_d;
            b_q      <= b_d;
            add_q    <= add_d;
            op_q     <= op_d;
            acc_q    <= acc_d;
        end
    end

    assign s_out  = s_q;
    assign pronto = pronto_q;
    assign err    = err_q;

endmodule

// File: tb/tb_bloco_operacional.sv
// tb/tb_bloco_operacional.sv - scoreboard bench for bloco_operacional
// Stimulus queues expected latencies and state snapshots; the monitor checks them as the DUT presents them.

module tb_bloco_operacional;

    logic        ck = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  x_in = 8'd0;
    logic        lx = 1'b0;
    logic [1:0]  m0 = 2'd0;
    logic [1:0]  m1 = 2'd0;
    logic [1:0]  m2 = 2'd0;
    logic        h = 1'b0;
    logic        lh = 1'b0;
    logic        ls = 1'b0;
    logic [15:0] s_out;
    logic        pronto;
    logic        err;

    typedef struct {
        logic [15:0] s;
        logic        p;
        logic        e;
    } snap_t;

    int    tests = 0;
    int    fails = 0;
    int    lat_q[$];
    snap_t snap_q[$];
    logic  chk_req = 1'b0;
    int    low_cnt = 0;
    int    exp_lat;
    snap_t exp_snap;

    bloco_operacional dut (
        .ck     (ck),
        .rst    (rst),
        .x_in   (x_in),
        .lx     (lx),
        .m0     (m0),
        .m1     (m1),
        .m2     (m2),
        .h      (h),
        .lh     (lh),
        .ls     (ls),
        .s_out  (s_out),
        .pronto (pronto),
        .err    (err)
    );

    always #5 ck = ~ck;

    // Monitor: pronto low-time against the latency queue, snapshots on request.
    always @(posedge ck) begin
        #1;
        if (!pronto) begin
            low_cnt++;
            if (low_cnt == 60) begin
                tests++;
                fails++;
                $display("FAIL pronto_timeout: low for %0d cycles, required at most 59", low_cnt);
            end
        end else if (low_cnt > 0) begin
            tests++;
            if (lat_q.size() == 0) begin
                fails++;
                $display("FAIL latency: unexpected pronto rise after %0d cycles, required none", low_cnt);
            end else begin
                exp_lat = lat_q.pop_front();
                if (low_cnt != exp_lat) begin
                    fails++;
                    $display("FAIL latency: pronto low %0d cycles, required %0d", low_cnt, exp_lat);
                end
            end
            low_cnt = 0;
        end
        if (chk_req && snap_q.size() > 0) begin
            exp_snap = snap_q.pop_front();
            tests += 3;
            if (s_out !== exp_snap.s) begin
                fails++;
                $display("FAIL s_out: got 0x%04h, required 0x%04h", s_out, exp_snap.s);
            end
            if (pronto !== exp_snap.p) begin
                fails++;
                $display("FAIL pronto: got %0b, required %0b", pronto, exp_snap.p);
            end
            if (err !== exp_snap.e) begin
                fails++;
                $display("FAIL err: got %0b, required %0b", err, exp_snap.e);
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge ck);
    endtask

    task automatic expect_state(input logic [15:0] s, input logic p, input logic e);
        snap_t sn;
        sn.s = s;
        sn.p = p;
        sn.e = e;
        snap_q.push_back(sn);
        chk_req = 1'b1;
        @(negedge ck);
        chk_req = 1'b0;
    endtask

    task automatic pulse_lx(input logic [7:0] v);
        x_in = v;
        lx   = 1'b1;
        tick(1);
        lx   = 1'b0;
    endtask

    task automatic pulse_ls();
        ls = 1'b1;
        tick(1);
        ls = 1'b0;
    endtask

    task automatic pulse_lh();
        lh = 1'b1;
        tick(1);
        lh = 1'b0;
    endtask

    initial begin
        tick(2);
        rst = 1'b0;
        // Reset state, then idle with no control change.
        for (int i = 0; i < 4; i++) expect_state(16'h0000, 1'b1, 1'b0);

        // X=4, multiply X*K1 = 20.
        pulse_lx(8'd4);
        m0 = 2'b01; m1 = 2'b01; h = 1'b1;
        lat_q.push_back(8);
        tick(10);
        // lh and ls together: both take R=20; the H write restarts the multiply.
        lat_q.push_back(8);
        lh = 1'b1; ls = 1'b1;
        tick(1);
        lh = 1'b0; ls = 1'b0;
        expect_state(16'd20, 1'b0, 1'b0);
        tick(10);

        // Add H + K2 = 27.
        m0 = 2'b10; m2 = 2'b10; h = 1'b0;
        lat_q.push_back(1);
        tick(3);
        pulse_ls();
        expect_state(16'h001B, 1'b1, 1'b0);

        // Multiply X*K1, switched to X*K2 at the 4th iteration: restart, 28.
        m0 = 2'b01; m1 = 2'b01; h = 1'b1;
        lat_q.push_back(12);
        tick(4);
        m1 = 2'b10;
        tick(14);
        pulse_ls();
        expect_state(16'd28, 1'b1, 1'b0);

        // Build H = 0x40*0x40 = 0x1000.
        pulse_lx(8'h40);
        m1 = 2'b00;
        lat_q.push_back(8);
        tick(10);
        lat_q.push_back(8);
        pulse_lh();
        tick(10);
        // H*H[7:0] = 0x1000*0x00 = 0.
        m0 = 2'b10; m1 = 2'b11;
        lat_q.push_back(8);
        tick(10);
        pulse_ls();
        expect_state(16'h0000, 1'b1, 1'b0);
        // H*X with X=0x20: 0x20000 truncates to 0.
        pulse_lx(8'h20);
        m1 = 2'b00;
        lat_q.push_back(8);
        tick(10);
        pulse_ls();
        expect_state(16'h0000, 1'b1, 1'b0);

        // H*K1 = 0x5000 with lh mid-multiply: err set, H kept.
        m1 = 2'b01;
        lat_q.push_back(8);
        tick(2);
        pulse_lh();
        tick(8);
        expect_state(16'h0000, 1'b1, 1'b1);
        pulse_ls();
        expect_state(16'h5000, 1'b1, 1'b1);
        m0 = 2'b10; m2 = 2'b00; h = 1'b0;
        lat_q.push_back(1);
        tick(3);
        pulse_ls();
        expect_state(16'h1000, 1'b1, 1'b1);

        // Reset mid-multiply clears everything including err.
        m0 = 2'b01; m1 = 2'b01; h = 1'b1;
        lat_q.push_back(3);
        tick(3);
        rst = 1'b1; m0 = 2'b00; m1 = 2'b00; m2 = 2'b00; h = 1'b0;
        tick(1);
        rst = 1'b0;
        expect_state(16'h0000, 1'b1, 1'b0);
        pulse_ls();
        expect_state(16'h0000, 1'b1, 1'b0);

        tick(3);
        tests++;
        if (lat_q.size() != 0 || low_cnt != 0) begin
            fails++;
            $display("FAIL drain: %0d latencies pending, pronto low %0d, required 0 and 0", lat_q.size(), low_cnt);
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
